// File: rtl/gnn_inst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnn_inst_pkg
// Description : Instruction field positions, line geometry and store/load
//               state encoding shared by the result store and weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
package gnn_inst_pkg;

    // Bit positions of the 16-bit fields inside a 128-bit instruction
    localparam int BUF_START_LSB    = 32;
    localparam int LEN_LSB          = 48;
    localparam int DRAM_START_LSB   = 64;
    localparam int FIELD_WIDTH      = 16;

    // A buffer line is always this many stream beats
    localparam int C_BEATS_PER_LINE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_START  = 3'd2,
        ST_RD     = 3'd3,
        ST_LOAD   = 3'd4,
        ST_SEND   = 3'd5,
        ST_WAIT   = 3'd6,
        ST_DONE   = 3'd7
    } store_state_e;

endpackage
`default_nettype wire

// File: rtl/result_store_if.sv
`default_nettype none
// ============================================================================
// Module      : result_store_if
// Description : AXI4-Stream beat channel from the result store to the AXI
//               write master.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_store_if #(
    parameter int DATA_WIDTH = 512
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/result_store_unpack.sv
`default_nettype none
// ============================================================================
// Module      : result_store_unpack
// Description : Holds one buffer line and presents it as consecutive beats,
//               lowest slice first, advancing on each accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
module result_store_unpack #(
    parameter int DATA_WIDTH = 512,
    parameter int BEATS      = 16
) (
    input  wire logic                        kernel_clk,
    input  wire logic                        kernel_rst_n,
    input  wire logic                        i_load,
    input  wire logic                        i_accept,
    input  wire logic [DATA_WIDTH*BEATS-1:0] i_line_data,
    output logic      [DATA_WIDTH-1:0]       o_beat,
    output logic                             o_last_beat
);
    localparam int                 c_cnt_w     = $clog2(BEATS);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    logic [DATA_WIDTH*BEATS-1:0] r_shift;
    logic [c_cnt_w-1:0]          r_beat_cnt;

    // Line register: load a whole line, then drop the low slice per accepted beat
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_line_data;
        end else if (i_accept) begin
            r_shift <= r_shift >> DATA_WIDTH;
        end
    end

    // Beat index within the current line
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_beat_cnt <= '0;
        end else if (i_load) begin
            r_beat_cnt <= '0;
        end else if (i_accept) begin
            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
        end
    end

    assign o_beat      = r_shift[DATA_WIDTH-1:0];
    assign o_last_beat = (r_beat_cnt == c_last_beat);

endmodule
`default_nettype wire

// File: rtl/result_store.sv
`default_nettype none
// ============================================================================
// Module      : result_store
// Description : Reads finished result lines from the on-chip buffer and
//               streams them, 16 beats per line, to the AXI write master.
// Revision    : 1.0 - initial release
// ============================================================================
module result_store
    import gnn_inst_pkg::*;
#(
    parameter int C_INST_BIT_WIDTH   = 128,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 13
) (
    input  wire logic                                       kernel_clk,
    input  wire logic                                       kernel_rst_n,
    input  wire logic                                       ap_start,
    output logic                                            ap_done,
    input  wire logic [C_M_AXI_ADDR_WIDTH-1:0]              ctrl_addr_offset,
    input  wire logic [C_INST_BIT_WIDTH-1:0]                ctrl_instruction,
    output logic                                            buffer_r_en,
    output logic      [C_BUF_ADDR_WIDTH-1:0]                buffer_r_addr,
    input  wire logic [C_BEATS_PER_LINE*C_M_AXI_DATA_WIDTH-1:0] buffer_r_data,
    output logic                                            wr_start,
    output logic      [C_M_AXI_ADDR_WIDTH-1:0]              wr_addr_offset,
    output logic      [C_XFER_SIZE_WIDTH-1:0]               wr_xfer_size_in_bytes,
    input  wire logic                                       wr_done,
    result_store_if.master                                  m_axis
);
    // log2 of the bytes in one line; the transfer size is line_len shifted by this
    localparam int c_line_bytes_log2 = $clog2(C_BEATS_PER_LINE * C_M_AXI_DATA_WIDTH / 8);
    localparam int c_size_pad        = C_XFER_SIZE_WIDTH - C_BUF_ADDR_WIDTH - c_line_bytes_log2;
    localparam int c_addr_pad        = C_M_AXI_ADDR_WIDTH - FIELD_WIDTH;

    store_state_e                  r_state;
    store_state_e                  w_state_nxt;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_buf_start;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_line_len;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_line_cnt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_wr_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_wr_size;
    logic                          r_post_rst_done;

    logic                          w_wr_start;
    logic                          w_rd_en;
    logic                          w_load;
    logic                          w_tvalid;
    logic                          w_done;
    logic                          w_accept;
    logic                          w_last_beat;
    logic                          w_last_line;
    logic [C_BUF_ADDR_WIDTH-1:0]   w_line_cnt_inc;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_beat;
    logic                          w_unused_inst_bits;

    // Instruction bits this block never looks at
    assign w_unused_inst_bits = ^{ctrl_instruction[C_INST_BIT_WIDTH-1:DRAM_START_LSB+FIELD_WIDTH],
                                  ctrl_instruction[LEN_LSB+FIELD_WIDTH-1:LEN_LSB+C_BUF_ADDR_WIDTH],
                                  ctrl_instruction[BUF_START_LSB+FIELD_WIDTH-1:BUF_START_LSB+C_BUF_ADDR_WIDTH],
                                  ctrl_instruction[BUF_START_LSB-1:0]};

    assign w_accept       = w_tvalid & m_axis.tready;
    assign w_line_cnt_inc = r_line_cnt + C_BUF_ADDR_WIDTH'(1);
    assign w_last_line    = (w_line_cnt_inc == r_line_len);

    // State register
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_start  = 1'b0;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_tvalid    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_nxt = (r_line_len == '0) ? ST_DONE : ST_START;
            end
            ST_START: begin
                w_wr_start  = 1'b1;
                w_state_nxt = ST_RD;
            end
            ST_RD: begin
                w_rd_en     = 1'b1;
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_tvalid = 1'b1;
                if (w_accept && w_last_beat) begin
                    w_state_nxt = w_last_line ? ST_WAIT : ST_RD;
                end
            end
            ST_WAIT: begin
                if (wr_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the instruction fields and derived write parameters on an accepted start
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_buf_start <= '0;
            r_line_len  <= '0;
            r_wr_addr   <= '0;
            r_wr_size   <= '0;
        end else if (r_state == ST_IDLE && ap_start) begin
            r_buf_start <= ctrl_instruction[BUF_START_LSB +: C_BUF_ADDR_WIDTH];
            r_line_len  <= ctrl_instruction[LEN_LSB +: C_BUF_ADDR_WIDTH];
            r_wr_addr   <= ctrl_addr_offset +
                           {{c_addr_pad{1'b0}}, ctrl_instruction[DRAM_START_LSB +: FIELD_WIDTH]};
            r_wr_size   <= {{c_size_pad{1'b0}},
                            ctrl_instruction[LEN_LSB +: C_BUF_ADDR_WIDTH],
                            {c_line_bytes_log2{1'b0}}};
        end
    end

    // Line counter: cleared at transfer start, advanced after each line's last beat
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_line_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_line_cnt <= '0;
        end else if (w_accept && w_last_beat) begin
            r_line_cnt <= w_line_cnt_inc;
        end
    end

    // ap_done is high through reset and for the first cycle after release
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_post_rst_done <= 1'b1;
        end else begin
            r_post_rst_done <= 1'b0;
        end
    end

    result_store_unpack #(
        .DATA_WIDTH (C_M_AXI_DATA_WIDTH),
        .BEATS      (C_BEATS_PER_LINE)
    ) u_unpack (
        .kernel_clk   (kernel_clk),
        .kernel_rst_n (kernel_rst_n),
        .i_load       (w_load),
        .i_accept     (w_accept),
        .i_line_data  (buffer_r_data),
        .o_beat       (w_beat),
        .o_last_beat  (w_last_beat)
    );

    assign ap_done               = r_post_rst_done | w_done;
    assign wr_start              = w_wr_start;
    assign wr_addr_offset        = r_wr_addr;
    assign wr_xfer_size_in_bytes = r_wr_size;
    assign buffer_r_en           = w_rd_en;
    assign buffer_r_addr         = w_rd_en ? (r_buf_start + r_line_cnt) : '0;
    assign m_axis.tvalid         = w_tvalid;
    assign m_axis.tdata          = w_beat;
    assign m_axis.tlast          = w_tvalid & w_last_beat & w_last_line;

endmodule
`default_nettype wire

// File: tb/tb_result_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_store
// Description : Directed, table-driven bench for result_store with a
//               procedural line buffer and a beat/handshake monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_store;

    typedef struct {
        logic [12:0] bs;
        logic [12:0] len;
        logic [15:0] ds;
        logic [63:0] off;
        logic [63:0] exp_addr;
        logic [31:0] exp_size;
        bit          rnd;
        bit          busy;
    } vec_t;

    typedef struct {
        logic [511:0] d;
        logic         l;
    } beat_t;

    logic          kernel_clk = 1'b0;
    logic          kernel_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_done;
    logic [63:0]   ctrl_addr_offset = '0;
    logic [127:0]  ctrl_instruction = '0;
    logic          buffer_r_en;
    logic [12:0]   buffer_r_addr;
    logic [8191:0] buffer_r_data = '0;
    logic          wr_start;
    logic [63:0]   wr_addr_offset;
    logic [31:0]   wr_xfer_size_in_bytes;
    logic          wr_done = 1'b0;

    result_store_if #(.DATA_WIDTH(512)) m_axis_if ();

    result_store u_dut (
        .kernel_clk            (kernel_clk),
        .kernel_rst_n          (kernel_rst_n),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ctrl_addr_offset      (ctrl_addr_offset),
        .ctrl_instruction      (ctrl_instruction),
        .buffer_r_en           (buffer_r_en),
        .buffer_r_addr         (buffer_r_addr),
        .buffer_r_data         (buffer_r_data),
        .wr_start              (wr_start),
        .wr_addr_offset        (wr_addr_offset),
        .wr_xfer_size_in_bytes (wr_xfer_size_in_bytes),
        .wr_done               (wr_done),
        .m_axis                (m_axis_if)
    );

    always #5 kernel_clk = ~kernel_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          mon_en = 1'b0;
    bit          start_seen, tv_seen, prev_stall;
    int          start_cyc, wrs_n, wrs_cyc, tv_cyc, done_n, done_cyc, wrd_cyc;
    logic [63:0] wrs_addr;
    logic [31:0] wrs_size;
    logic [511:0] prev_d;
    logic        prev_l;
    logic [12:0] rd_q[$];
    int          rd_cyc_q[$];
    beat_t       beats_q[$];
    vec_t        vecs[6];

    // Every 32-bit word of a line is unique: {3'b0, line address, word index, 0x5A}
    function automatic logic [8191:0] line_of(input logic [12:0] a);
        logic [8191:0] v;
        for (int w = 0; w < 256; w++) v[w*32 +: 32] = {3'b000, a, 8'(w), 8'h5A};
        return v;
    endfunction

    // Instruction with junk in every ignored bit position
    function automatic logic [127:0] pack(input vec_t v);
        logic [127:0] i;
        i[127:96] = 32'h1234_5678;
        i[95:80]  = 16'hDEAD;
        i[79:64]  = v.ds;
        i[63:48]  = {3'b010, v.len};
        i[47:32]  = {3'b101, v.bs};
        i[31:0]   = 32'hCAFE_BABE;
        return i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Buffer with one-cycle read latency
    always @(posedge kernel_clk) begin
        if (buffer_r_en) buffer_r_data <= line_of(buffer_r_addr);
    end

    always @(posedge kernel_clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge
    always @(negedge kernel_clk) begin
        if (mon_en) begin
            if (ap_start && !start_seen) begin start_seen = 1'b1; start_cyc = cyc; end
            if (wr_start) begin
                wrs_n++;
                if (wrs_n == 1) begin
                    wrs_cyc = cyc; wrs_addr = wr_addr_offset; wrs_size = wr_xfer_size_in_bytes;
                end
            end
            if (buffer_r_en) begin
                check("rd_not_ahead", 64'(beats_q.size()), 64'(rd_q.size() * 16));
                rd_q.push_back(buffer_r_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (m_axis_if.tvalid) begin
                if (!tv_seen) begin tv_seen = 1'b1; tv_cyc = cyc; end
                if (prev_stall) begin
                    check("hold_tdata", {63'b0, m_axis_if.tdata !== prev_d}, 64'd0);
                    check("hold_tlast", {63'b0, m_axis_if.tlast}, {63'b0, prev_l});
                end
            end
            prev_stall = m_axis_if.tvalid && !m_axis_if.tready;
            prev_d     = m_axis_if.tdata;
            prev_l     = m_axis_if.tlast;
            if (m_axis_if.tvalid && m_axis_if.tready)
                beats_q.push_back('{d: m_axis_if.tdata, l: m_axis_if.tlast});
            if (wr_done) wrd_cyc = cyc;
            if (ap_done) begin done_n++; done_cyc = cyc; end
        end
    end

    task automatic clear_mon();
        start_seen = 1'b0; tv_seen = 1'b0; prev_stall = 1'b0;
        start_cyc = -1; wrs_n = 0; wrs_cyc = -1; tv_cyc = -1;
        done_n = 0; done_cyc = -1; wrd_cyc = -1;
        rd_q.delete(); rd_cyc_q.delete(); beats_q.delete();
    endtask

    // Called at posedge+1; returns at the next posedge+1 with ap_start low
    task automatic start_instr(input vec_t v);
        clear_mon();
        ctrl_instruction = pack(v);
        ctrl_addr_offset = v.off;
        ap_start = 1'b1;
        @(posedge kernel_clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          nb, budget, wait_cnt;
        bit          wrd_sent, early_sent, busy_sent;
        logic [12:0] ea;
        logic [8191:0] ln;
        logic [511:0] eb;
        nb = int'(v.len) * 16;
        budget = nb * 8 + 60;
        wait_cnt = 0; wrd_sent = 0; early_sent = 0; busy_sent = 0;
        start_instr(v);
        for (int c = 0; c < budget && done_n == 0; c++) begin
            m_axis_if.tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_done  = 1'b0;
            ap_start = 1'b0;
            if (v.rnd && !early_sent && beats_q.size() >= 5) begin
                wr_done = 1'b1;              // stray wr_done during SEND
                early_sent = 1'b1;
            end else if (!wrd_sent && wrs_n > 0 && beats_q.size() == nb) begin
                if (wait_cnt == 2) begin wr_done = 1'b1; wrd_sent = 1'b1; end
                wait_cnt++;
            end
            if (v.busy && !busy_sent && beats_q.size() >= 2) begin
                ap_start = 1'b1;
                ctrl_instruction = ~pack(v);
                ctrl_addr_offset = 64'h7777_0000;
                busy_sent = 1'b1;
            end
            @(posedge kernel_clk); #1;
        end
        wr_done = 1'b0; ap_start = 1'b0; m_axis_if.tready = 1'b1;
        repeat (4) begin @(posedge kernel_clk); #1; end

        check($sformatf("v%0d_done_count", idx), 64'(done_n), 64'd1);
        if (v.len != 0) begin
            check($sformatf("v%0d_wr_start_count", idx), 64'(wrs_n), 64'd1);
            check($sformatf("v%0d_wr_addr", idx), wrs_addr, v.exp_addr);
            check($sformatf("v%0d_wr_size", idx), 64'(wrs_size), 64'(v.exp_size));
            check($sformatf("v%0d_lat_wr_start", idx), 64'(wrs_cyc - start_cyc), 64'd2);
            check($sformatf("v%0d_lat_tvalid", idx), 64'(tv_cyc - start_cyc), 64'd5);
            check($sformatf("v%0d_rd_count", idx), 64'(rd_q.size()), 64'(v.len));
            if (rd_cyc_q.size() > 0)
                check($sformatf("v%0d_lat_rd", idx), 64'(rd_cyc_q[0] - start_cyc), 64'd3);
            for (int i = 0; i < rd_q.size(); i++) begin
                ea = v.bs + 13'(i);
                check($sformatf("v%0d_rd_addr%0d", idx, i), 64'(rd_q[i]), 64'(ea));
            end
            check($sformatf("v%0d_beat_count", idx), 64'(beats_q.size()), 64'(nb));
            for (int i = 0; i < beats_q.size(); i++) begin
                ln = line_of(v.bs + 13'(i / 16));
                eb = ln[(i % 16)*512 +: 512];
                checks++;
                if (beats_q[i].d !== eb || beats_q[i].l !== (i == nb - 1)) begin
                    failures++;
                    $display("FAIL v%0d_beat%0d: got data[63:0]=0x%0h last=%0b expected data[63:0]=0x%0h last=%0b",
                             idx, i, beats_q[i].d[63:0], beats_q[i].l, eb[63:0], (i == nb - 1));
                end
            end
            check($sformatf("v%0d_done_after_wr_done", idx), 64'(done_cyc - wrd_cyc), 64'd1);
            check($sformatf("v%0d_addr_hold", idx), wr_addr_offset, v.exp_addr);
            if (!v.rnd && rd_cyc_q.size() > 1)
                check($sformatf("v%0d_line_period", idx), 64'(rd_cyc_q[1] - rd_cyc_q[0]), 64'd18);
        end else begin
            check($sformatf("v%0d_wr_start_count", idx), 64'(wrs_n), 64'd0);
            check($sformatf("v%0d_rd_count", idx), 64'(rd_q.size()), 64'd0);
            check($sformatf("v%0d_beat_count", idx), 64'(beats_q.size()), 64'd0);
            check($sformatf("v%0d_lat_done", idx), 64'(done_cyc - start_cyc), 64'd2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          bs        len    ds        off                      exp_addr                 size      rnd busy
        vecs[0] = '{13'h0010, 13'd1, 16'h0040, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0040, 32'd1024, 0, 0};
        vecs[1] = '{13'h0010, 13'd3, 16'h0080, 64'h0000_0000_2000_0000, 64'h0000_0000_2000_0080, 32'd3072, 1, 0};
        vecs[2] = '{13'h0005, 13'd0, 16'h0000, 64'h0000_0000_0000_3000, 64'h0000_0000_0000_3000, 32'd0,    0, 0};
        vecs[3] = '{13'h1FFF, 13'd2, 16'hFFFF, 64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2048, 0, 0};
        vecs[4] = '{13'h0100, 13'd2, 16'h0200, 64'h0000_0000_4000_0000, 64'h0000_0000_4000_0200, 32'd2048, 0, 1};
        vecs[5] = '{13'h0020, 13'd1, 16'h0010, 64'h0000_0000_0000_5000, 64'h0000_0000_0000_5010, 32'd1024, 0, 0};
        m_axis_if.tready = 1'b1;
        clear_mon();

        // Reset state
        repeat (3) @(posedge kernel_clk);
        #1;
        check("rst_ap_done", {63'b0, ap_done}, 64'd1);
        check("rst_tvalid", {63'b0, m_axis_if.tvalid}, 64'd0);
        check("rst_tlast", {63'b0, m_axis_if.tlast}, 64'd0);
        check("rst_wr_start", {63'b0, wr_start}, 64'd0);
        check("rst_rd_en", {63'b0, buffer_r_en}, 64'd0);
        check("rst_wr_addr", wr_addr_offset, 64'd0);
        check("rst_wr_size", 64'(wr_xfer_size_in_bytes), 64'd0);
        kernel_rst_n = 1'b1;
        #1;
        check("rel_ap_done_held", {63'b0, ap_done}, 64'd1);
        @(posedge kernel_clk); #1;
        check("rel_ap_done_drop", {63'b0, ap_done}, 64'd0);
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

        // Reset while beat 7 of a single-line transfer is on the bus
        start_instr(vecs[0]);
        for (int c = 0; c < 100; c++) begin
            if (beats_q.size() >= 7) break;
            @(posedge kernel_clk); #1;
        end
        check("mid_reach_beat7", 64'(beats_q.size()), 64'd7);
        #2;
        kernel_rst_n = 1'b0;
        #1;
        check("mid_tvalid", {63'b0, m_axis_if.tvalid}, 64'd0);
        check("mid_rd_en", {63'b0, buffer_r_en}, 64'd0);
        check("mid_wr_start", {63'b0, wr_start}, 64'd0);
        check("mid_ap_done", {63'b0, ap_done}, 64'd1);
        repeat (2) @(posedge kernel_clk);
        #1;
        kernel_rst_n = 1'b1;
        #1;
        check("mid_rel_ap_done_held", {63'b0, ap_done}, 64'd1);
        @(posedge kernel_clk); #1;
        check("mid_rel_ap_done_drop", {63'b0, ap_done}, 64'd0);
        clear_mon();
        repeat (6) begin @(posedge kernel_clk); #1; end
        check("mid_quiet_wr_start", 64'(wrs_n), 64'd0);
        check("mid_quiet_ap_done", 64'(done_n), 64'd0);
        check("mid_quiet_reads", 64'(rd_q.size()), 64'd0);

        run_vec(5, vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_store.md
# result_store

- Moves finished result lines from the on-chip buffer to DRAM.
- Reads one 16×512-bit line at a time through the buffer read port and serializes it into 16 AXI4-Stream beats.
- Feeds those beats to the AXI write master, which the parent instantiates.
- It is the write-direction counterpart of the weight loader and shares that loader's instruction format and ap_start/ap_done handshake with ctrl.

## Interface
- C_INST_BIT_WIDTH, 128, instruction width
- C_M_AXI_ADDR_WIDTH, 64, DRAM address width
- C_M_AXI_DATA_WIDTH, 512, stream beat width
- C_XFER_SIZE_WIDTH, 32, transfer-size width
- C_BUF_ADDR_WIDTH, 13, buffer line address width
- C_BEATS_PER_LINE, 16, beats per buffer line (fixed; the line is C_BEATS_PER_LINE*C_M_AXI_DATA_WIDTH bits)

Ports:
- kernel_clk  in  1  sole clock
- kernel_rst_n  in  1  reset, asynchronous, active-low; one clock, async active-low reset
- ap_start  in  1  start pulse from ctrl
- ap_done  out  1  completion pulse to ctrl
- ctrl_addr_offset  in  64  DRAM base address
- ctrl_instruction  in  128  store instruction
- buffer_r_en  out  1  buffer read enable
- buffer_r_addr  out  13  buffer line address
- buffer_r_data  in  8192  line data, valid one cycle after buffer_r_en
- wr_start  out  1  one-cycle start pulse to the write master
- wr_addr_offset  out  64  DRAM start byte address
- wr_xfer_size_in_bytes  out  32  transfer size
- wr_done  in  1  write master pulse: all write responses received
- m_axis_tvalid / m_axis_tready / m_axis_tdata[512] / m_axis_tlast  out/in/out/out  beat stream to the write master

## Operation
- **Instruction decode** (latched on ap_start in IDLE):
  - buf_start = inst[47:32], low 13 bits used
  - line_len = inst[63:48], low 13 bits used
  - dram_start = inst[79:64]
  - inst[95:80] ignored
- **Derived values:**
  - wr_addr_offset = ctrl_addr_offset + zero-extended dram_start
  - wr_xfer_size_in_bytes = line_len × 1024, computed in 32 bits
- **State machine:**
  - IDLE: on ap_start → DECODE. ap_start in any other state is ignored.
  - DECODE: latch the fields. If line_len==0 → DONE, else → START.
  - START: wr_start=1 for one cycle, line counter=0 → RD.
  - RD: buffer_r_en=1, buffer_r_addr = buf_start + line counter (13-bit wrap) → LOAD.
  - LOAD: capture buffer_r_data into the shift register, beat counter=0 → SEND.
  - SEND: m_axis_tvalid=1, m_axis_tdata = shift[511:0].
    - On tvalid&&tready: shift right by 512 and increment the beat counter.
    - Beat k of a line is line[k*512 +: 512], low slice first (the inverse of the loader's packing).
    - After beat 15 is accepted: increment the line counter, then → RD if more lines remain, else → WAIT.
  - WAIT: → DONE on wr_done.
  - DONE: ap_done=1 for one cycle → IDLE.
- m_axis_tlast=1 only on beat 15 of the final line.
- tdata and tlast are held stable while tvalid && !tready.

## Timing
- **Reset values:**
  - ap_done=1; deasserts on the first clock edge after reset release.
  - All other outputs 0; state=IDLE.
- **Reset mid-operation:** outputs drop asynchronously. No wr_start or ap_done follows release except the post-reset ap_done pulse.
- **Latency:**
  - ap_start → wr_start: 2 cycles.
  - ap_start → first buffer_r_en: 3 cycles.
  - ap_start → first tvalid: 5 cycles.
- **Throughput:** 18 cycles per line with tready held high (RD, LOAD, 16 SEND).
- **ap_done:** asserted the cycle after wr_done is sampled in WAIT. With line_len==0 it asserts 2 cycles after ap_start and wr_start never fires.
- **wr_done outside WAIT:** ignored.
- **Backpressure:** tready low stalls in SEND with no data loss. Buffer reads never run ahead of the current line.
- **Line counter:** 13 bits; line_len max 8191.

## Structure
- **Package gnn_inst_pkg:** instruction field bit positions (BUF_START_LSB=32, LEN_LSB=48, DRAM_START_LSB=64), C_BEATS_PER_LINE, state enum typedef. The weight loader uses the same package.
- **Sub-module result_store_unpack:** 8192-bit shift register plus beat counter. Inputs: load and beat accept. Outputs: current beat and last_beat.

## Test plan
- **One line:** line_len=1, buf_start=0x10, dram_start=0x40, offset=0x1000_0000.
  - Expect buffer_r_addr=0x10.
  - Expect wr_addr_offset=0x1000_0040 and size=1024.
  - Expect 16 beats equal to line slices 0..15 in order, tlast on the 16th.
  - Expect ap_done one cycle after wr_done.
- **Three lines with random tready (50%):** addresses 0x10..0x12, 48 beats in order, exactly one tlast, size=3072.
- **Address wrap:** line_len=0, then buf_start=0x1FFF with line_len=2.
  - First instruction: ap_done 2 cycles after ap_start, no wr_start, no buffer read.
  - Second instruction: reads 0x1FFF then 0x0000.
- **Busy start:** ap_start pulsed during SEND of line 0 → ignored; transfer and addresses unchanged, one ap_done.
- **Reset mid-transfer:** assert kernel_rst_n=0 during beat 7.
  - Expect tvalid=0 and buffer_r_en=0 immediately.
  - Expect the ap_done reset pulse, and a new instruction completes normally.
